axis_burst_source: RTL and testbench

//  Upstream AXI4-Stream master that feeds the neutral_axis_v1_0 s_axis_in port.
//  On a start pulse it emits NUM_PKTS packets of PKT_LEN beats each, back-to-back.

---
 rtl/axis_src_pkg.sv | 21 ++
 rtl/axis_burst_source.sv | 134 +++++++++++++
 tb/tb_axis_burst_source.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/axis_src_pkg.sv
// Shared types and defaults for the AXI4-Stream burst source.
package axis_src_pkg;

    typedef enum logic {ST_IDLE, ST_RUN} src_state_t;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_LEN_WIDTH  = 16;
    localparam int AXIS_CNT_WIDTH  = 8;
    localparam int STRB_MAX        = 128;

    // Returns a mask with the low 'width' bits set; callers slice it to size.
    function automatic logic [STRB_MAX-1:0] strb_all_ones(input int width);
        logic [STRB_MAX-1:0] mask;
        mask = '0;
        for (int i = 0; i < STRB_MAX; i++) begin
            if (i < width) mask[i] = 1'b1;
        end
        return mask;
    endfunction

endpackage

// File: rtl/axis_burst_source.sv
// AXI4-Stream master emitting num_pkts packets of pkt_len incrementing words per start,
// honouring tready back-pressure with fully registered outputs.
module axis_burst_source
    import axis_src_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int LEN_WIDTH  = AXIS_LEN_WIDTH,
    parameter int CNT_WIDTH  = AXIS_CNT_WIDTH
) (
    input  logic                    aclk,
    input  logic                    areset,
    input  logic                    start,
    input  logic [LEN_WIDTH-1:0]    pkt_len,
    input  logic [CNT_WIDTH-1:0]    num_pkts,
    input  logic [DATA_WIDTH-1:0]   seed,
    output logic                    busy,
    output logic                    done,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tstrb,
    output logic                    m_axis_tlast
);

    localparam int STRB_W = DATA_WIDTH / 8;
    localparam logic [STRB_W-1:0] STRB_ONES = STRB_W'(strb_all_ones(STRB_W));

    src_state_t            state_q,    state_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic [CNT_WIDTH-1:0]  pkt_cnt_q,  pkt_cnt_d;
    logic [LEN_WIDTH-1:0]  len_q,      len_d;
    logic [CNT_WIDTH-1:0]  num_q,      num_d;
    logic [DATA_WIDTH-1:0] tdata_q,    tdata_d;
    logic [STRB_W-1:0]     tstrb_q,    tstrb_d;
    logic                  tvalid_q,   tvalid_d;
    logic                  tlast_q,    tlast_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  handshake;

    assign handshake = tvalid_q & m_axis_tready;

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_q    <= ST_IDLE;
            beat_cnt_q <= '0;
            pkt_cnt_q  <= '0;
            len_q      <= '0;
            num_q      <= '0;
            tdata_q    <= '0;
            tstrb_q    <= '0;
            tvalid_q   <= 1'b0;
            tlast_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            len_q      <= len_d;
            num_q      <= num_d;
            tdata_q    <= tdata_d;
            tstrb_q    <= tstrb_d;
            tvalid_q   <= tvalid_d;
            tlast_q    <= tlast_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // tlast is precomputed for the beat that will be presented next, so it stays registered.
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        len_d      = len_q;
        num_d      = num_q;
        tdata_d    = tdata_q;
        tstrb_d    = tstrb_q;
        tvalid_d   = tvalid_q;
        tlast_d    = tlast_q;
        busy_d     = busy_q;
        done_d     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start && (pkt_len != '0) && (num_pkts != '0)) begin
                    state_d    = ST_RUN;
                    len_d      = pkt_len;
                    num_d      = num_pkts;
                    tdata_d    = seed;
                    beat_cnt_d = '0;
                    pkt_cnt_d  = '0;
                    tvalid_d   = 1'b1;
                    tstrb_d    = STRB_ONES;
                    tlast_d    = (pkt_len == LEN_WIDTH'(1));
                    busy_d     = 1'b1;
                end
            end
            ST_RUN: begin
                if (handshake) begin
                    tdata_d = tdata_q + DATA_WIDTH'(1);
                    if (tlast_q) begin
                        beat_cnt_d = '0;
                        if (pkt_cnt_q == num_q - CNT_WIDTH'(1)) begin
                            state_d   = ST_IDLE;
                            pkt_cnt_d = '0;
                            tvalid_d  = 1'b0;
                            tstrb_d   = '0;
                            tlast_d   = 1'b0;
                            busy_d    = 1'b0;
                            done_d    = 1'b1;
                        end else begin
                            pkt_cnt_d = pkt_cnt_q + CNT_WIDTH'(1);
                            tlast_d   = (len_q == LEN_WIDTH'(1));
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + LEN_WIDTH'(1);
                        tlast_d    = (beat_cnt_q + LEN_WIDTH'(1) == len_q - LEN_WIDTH'(1));
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tdata  = tdata_q;
    assign m_axis_tstrb  = tstrb_q;
    assign m_axis_tlast  = tlast_q;

endmodule

// File: tb/tb_axis_burst_source.sv
// Directed and randomized bursts against a beat-list reference model of the burst source.
module tb_axis_burst_source;

    logic        aclk = 1'b0;
    logic        areset;
    logic        start;
    logic [15:0] pkt_len;
    logic [7:0]  num_pkts;
    logic [31:0] seed;
    logic        busy;
    logic        done;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic [31:0] m_axis_tdata;
    logic [3:0]  m_axis_tstrb;
    logic        m_axis_tlast;

    int n_total = 0;
    int n_pass  = 0;

    axis_burst_source dut (
        .aclk          (aclk),
        .areset        (areset),
        .start         (start),
        .pkt_len       (pkt_len),
        .num_pkts      (num_pkts),
        .seed          (seed),
        .busy          (busy),
        .done          (done),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tstrb  (m_axis_tstrb),
        .m_axis_tlast  (m_axis_tlast)
    );

    always #5 aclk = ~aclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_total++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    endtask

    task automatic check_idle(input string tag, input logic exp_done);
        check({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check({tag, " busy"},   64'(busy),          64'd0);
        check({tag, " done"},   64'(done),          64'(exp_done));
        check({tag, " tstrb"},  64'(m_axis_tstrb),  64'd0);
        check({tag, " tlast"},  64'(m_axis_tlast),  64'd0);
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            check_idle(tag, 1'b0);
        end
    endtask

    // Starts at a negedge; ends at the negedge of the done cycle after checking it.
    // mode: 0 = tready always 1, 1 = tready toggles, 2 = random tready.
    task automatic run_burst(input string tag, input int len, input int num,
                             input logic [31:0] sd, input int mode, input bit poke_start);
        logic [31:0] exp_data[$];
        bit          exp_last[$];
        logic [31:0] word;
        int          idx;
        int          cyc;
        int          hs_cnt;
        logic        rdy;
        for (int p = 0; p < num; p++) begin
            for (int b = 0; b < len; b++) begin
                word = sd + 32'(p * len + b);
                exp_data.push_back(word);
                exp_last.push_back(b == len - 1);
            end
        end
        start    = 1'b1;
        pkt_len  = 16'(len);
        num_pkts = 8'(num);
        seed     = sd;
        rdy      = 1'b1;
        m_axis_tready = rdy;
        @(negedge aclk);
        start = 1'b0;
        idx = 0; cyc = 0; hs_cnt = 0;
        while (idx < exp_data.size()) begin
            if (cyc > 20 * exp_data.size() + 50) begin
                check({tag, " beat budget"}, 64'(idx), 64'(exp_data.size()));
                break;
            end
            check({tag, " tvalid"}, 64'(m_axis_tvalid), 64'd1);
            check({tag, " tdata"},  64'(m_axis_tdata),  64'(exp_data[idx]));
            check({tag, " tlast"},  64'(m_axis_tlast),  64'(exp_last[idx]));
            check({tag, " tstrb"},  64'(m_axis_tstrb),  64'hF);
            check({tag, " busy"},   64'(busy),          64'd1);
            check({tag, " done"},   64'(done),          64'd0);
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = (cyc == 0) ? 1'b1 : ~rdy;
                default: rdy = 1'($urandom_range(0, 1));
            endcase
            m_axis_tready = rdy;
            start = poke_start && (cyc == 2);
            if (start) begin
                pkt_len  = 16'd1;
                num_pkts = 8'd1;
                seed     = 32'hDEAD_BEEF;
            end
            if (rdy) begin
                idx++;
                hs_cnt++;
            end
            @(negedge aclk);
            cyc++;
        end
        start = 1'b0;
        check({tag, " handshakes"}, 64'(hs_cnt), 64'(exp_data.size()));
        check_idle({tag, " done-cycle"}, 1'b1);
        $display("burst %s len=%0d num=%0d seed=0x%08h beats=%0d cycles=%0d", tag, len, num, sd, hs_cnt, cyc);
    endtask

    initial begin
        areset        = 1'b1;
        start         = 1'b0;
        pkt_len       = '0;
        num_pkts      = '0;
        seed          = '0;
        m_axis_tready = 1'b0;
        #1;
        check_idle("reset", 1'b0);
        check("reset tdata", 64'(m_axis_tdata), 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        idle_cycles(2, "post-reset");

        run_burst("t1", 4, 1, 32'h10, 0, 1'b0);
        idle_cycles(1, "t1 after");

        // Back-to-back start issued in the done cycle.
        run_burst("t2", 3, 3, 32'h0, 0, 1'b0);
        run_burst("t2 chained", 2, 1, 32'h40, 0, 1'b0);
        idle_cycles(1, "t2 after");

        run_burst("t3", 5, 1, 32'h100, 1, 1'b0);
        idle_cycles(1, "t3 after");

        run_burst("t4", 4, 1, 32'hFFFF_FFFE, 0, 1'b0);
        idle_cycles(1, "t4 after");

        start = 1'b1; pkt_len = 16'd0; num_pkts = 8'd3; seed = 32'h55;
        @(negedge aclk);
        start = 1'b0;
        check_idle("t5 len0", 1'b0);
        idle_cycles(2, "t5 len0");
        start = 1'b1; pkt_len = 16'd4; num_pkts = 8'd0;
        @(negedge aclk);
        start = 1'b0;
        check_idle("t5 num0", 1'b0);
        idle_cycles(2, "t5 num0");
        run_burst("t5 start-in-run", 3, 2, 32'h200, 0, 1'b1);
        idle_cycles(1, "t5 after");

        // Reset while beat 2 of 8 is on the bus.
        start = 1'b1; pkt_len = 16'd8; num_pkts = 8'd1; seed = 32'h300;
        m_axis_tready = 1'b1;
        @(negedge aclk);
        start = 1'b0;
        @(negedge aclk);
        @(negedge aclk);
        check("t6 beat2 tdata", 64'(m_axis_tdata), 64'h302);
        check("t6 beat2 busy",  64'(busy),         64'd1);
        #1 areset = 1'b1;
        #1;
        check_idle("t6 in-reset", 1'b0);
        @(negedge aclk);
        areset = 1'b0;
        idle_cycles(2, "t6 released");
        run_burst("t6 restart", 8, 1, 32'h400, 0, 1'b0);
        idle_cycles(1, "t6 after");

        for (int k = 0; k < 6; k++) begin
            run_burst($sformatf("rnd%0d", k), int'($urandom_range(1, 6)), int'($urandom_range(1, 4)),
                      32'($urandom), 2, 1'($urandom_range(0, 1)));
            idle_cycles(int'($urandom_range(0, 2)), "rnd idle");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
